// File: rtl/uart_rx_fifo_if.sv
// Device-bus port bundle for the UART receiver slot.
interface uart_rx_fifo_if;
  logic        device_req_i;
  logic [31:0] device_addr_i;
  logic        device_we_i;
  logic [3:0]  device_be_i;
  logic [31:0] device_wdata_i;
  logic        device_rvalid_o;
  logic [31:0] device_rdata_o;

  modport master (
    output device_req_i, device_addr_i, device_we_i, device_be_i, device_wdata_i,
    input  device_rvalid_o, device_rdata_o
  );

  modport slave (
    input  device_req_i, device_addr_i, device_we_i, device_be_i, device_wdata_i,
    output device_rvalid_o, device_rdata_o
  );
endinterface

// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver with RX FIFO, status/control registers and a level
// data-available interrupt, attached to the system device bus.
module uart_rx_fifo #(
  parameter int unsigned ClockFrequency = 50_000_000,
  parameter int unsigned BaudRate       = 115200,
  parameter int unsigned FifoDepth      = 8
) (
  input  logic           clk_sys_i,
  input  logic           rst_sys_ni,
  uart_rx_fifo_if.slave  dev,
  input  logic           uart_rx_i,
  output logic           irq_o
);
  localparam int unsigned ClksPerBit = ClockFrequency / BaudRate;
  localparam int unsigned CntW       = $clog2(ClksPerBit + 1);
  localparam int unsigned PtrW       = $clog2(FifoDepth);
  localparam int unsigned LvlW       = PtrW + 1;
  localparam logic [CntW-1:0] BitLoad  = CntW'(ClksPerBit - 1);
  localparam logic [CntW-1:0] HalfLoad = CntW'(ClksPerBit / 2 - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;

  state_e          r_state;
  logic [CntW-1:0] r_cnt;
  logic [2:0]      r_bit;
  logic [7:0]      r_shift;
  logic            r_rx_meta, r_rx_s, r_rx_prev;
  logic [7:0]      r_mem [FifoDepth];
  logic [LvlW-1:0] r_wptr, r_rptr;
  logic            r_ovf, r_ferr, r_irq_en, r_irq;
  logic            r_rvalid;
  logic [31:0]     r_rdata;

  logic [LvlW-1:0] w_level;
  logic            w_empty, w_full;
  logic            w_frame_done, w_push, w_ferr_set, w_pop, w_push_ok, w_ovf_set;
  logic            w_rd, w_wr;
  logic [1:0]      w_sel;
  logic [31:0]     w_status;
  logic            w_unused_bits;

  assign w_level      = r_wptr - r_rptr;
  assign w_empty      = (w_level == '0);
  assign w_full       = (w_level == LvlW'(FifoDepth));
  assign w_sel        = dev.device_addr_i[3:2];
  assign w_rd         = dev.device_req_i & ~dev.device_we_i;
  assign w_wr         = dev.device_req_i & dev.device_we_i & dev.device_be_i[0];
  assign w_frame_done = (r_state == STOP) && (r_cnt == '0);
  assign w_push       = w_frame_done & r_rx_s;
  assign w_ferr_set   = w_frame_done & ~r_rx_s;
  assign w_pop        = w_rd & (w_sel == 2'd0) & ~w_empty;
  // A full FIFO still accepts a byte when the head leaves in the same cycle.
  assign w_push_ok    = w_push & (~w_full | w_pop);
  assign w_ovf_set    = w_push & w_full & ~w_pop;

  always_comb begin
    w_status       = '0;
    w_status[0]    = w_empty;
    w_status[1]    = w_full;
    w_status[2]    = r_ovf;
    w_status[3]    = r_ferr;
    w_status[14:8] = 7'(w_level);
  end

  assign w_unused_bits = ^{dev.device_addr_i[31:4], dev.device_addr_i[1:0],
                           dev.device_be_i[3:1], dev.device_wdata_i[31:4],
                           dev.device_wdata_i[1]};

  // Synchroniser and frame deserialiser.
  always_ff @(posedge clk_sys_i or negedge rst_sys_ni) begin
    if (!rst_sys_ni) begin
      r_rx_meta <= 1'b1;
      r_rx_s    <= 1'b1;
      r_rx_prev <= 1'b1;
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_bit     <= '0;
      r_shift   <= '0;
    end else begin
      r_rx_meta <= uart_rx_i;
      r_rx_s    <= r_rx_meta;
      r_rx_prev <= r_rx_s;
      case (r_state)
        IDLE: begin
          if (r_rx_prev && !r_rx_s) begin
            r_cnt   <= HalfLoad;
            r_state <= START;
          end
        end
        START: begin
          if (r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
          end else if (r_rx_s) begin
            r_state <= IDLE;
          end else begin
            r_cnt   <= BitLoad;
            r_bit   <= '0;
            r_state <= DATA;
          end
        end
        DATA: begin
          if (r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
          end else begin
            r_shift <= {r_rx_s, r_shift[7:1]};
            r_cnt   <= BitLoad;
            if (r_bit == 3'd7) r_state <= STOP;
            else               r_bit   <= r_bit + 1'b1;
          end
        end
        STOP: begin
          if (r_cnt != '0) r_cnt   <= r_cnt - 1'b1;
          else             r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_sys_i) begin
    if (w_push_ok) r_mem[r_wptr[PtrW-1:0]] <= r_shift;
  end

  // FIFO pointers, sticky flags, control and bus response.
  always_ff @(posedge clk_sys_i or negedge rst_sys_ni) begin
    if (!rst_sys_ni) begin
      r_wptr   <= '0;
      r_rptr   <= '0;
      r_ovf    <= 1'b0;
      r_ferr   <= 1'b0;
      r_irq_en <= 1'b0;
      r_irq    <= 1'b0;
      r_rvalid <= 1'b0;
      r_rdata  <= '0;
    end else begin
      if (w_push_ok) r_wptr <= r_wptr + 1'b1;
      if (w_pop)     r_rptr <= r_rptr + 1'b1;
      r_ovf  <= (r_ovf  & ~(w_wr && w_sel == 2'd1 && dev.device_wdata_i[2])) | w_ovf_set;
      r_ferr <= (r_ferr & ~(w_wr && w_sel == 2'd1 && dev.device_wdata_i[3])) | w_ferr_set;
      if (w_wr && w_sel == 2'd2) r_irq_en <= dev.device_wdata_i[0];
      r_irq    <= r_irq_en & ~w_empty;
      r_rvalid <= dev.device_req_i;
      r_rdata  <= '0;
      if (w_rd) begin
        case (w_sel)
          2'd0:    r_rdata <= w_empty ? 32'd0 : {24'd0, r_mem[r_rptr[PtrW-1:0]]};
          2'd1:    r_rdata <= w_status;
          2'd2:    r_rdata <= {31'd0, r_irq_en};
          default: r_rdata <= '0;
        endcase
      end
    end
  end

  assign dev.device_rvalid_o = r_rvalid;
  assign dev.device_rdata_o  = r_rdata;
  assign irq_o               = r_irq;
endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
Bus-attached UART receiver on the system device bus, in the same device slot style as the existing UART transmitter, GPIO and timer devices. It deserialises 8N1 frames from an external RX pin, buffers received bytes in a FIFO, exposes data, status and control registers to the core, and raises a level interrupt toward the core's fast-IRQ inputs when data is waiting.

Parameters:
ClockFrequency, 50_000_000, clk_sys_i frequency in Hz
BaudRate, 115200, line rate; ClksPerBit = ClockFrequency/BaudRate (integer divide, 434 at defaults)
FifoDepth, 8, RX FIFO entries; power of two, 2..64

Ports:
clk_sys_i  input  1  system clock
rst_sys_ni  input  1  reset
device_req_i  input  1  bus request, single cycle
device_addr_i  input  32  byte address; only bits [3:2] decoded
device_we_i  input  1  1 = write
device_be_i  input  4  byte enables; only be[0] used
device_wdata_i  input  32  write data
device_rvalid_o  output  1  response valid
device_rdata_o  output  32  read data
uart_rx_i  input  1  serial input, asynchronous, idle high
irq_o  output  1  RX-data-available interrupt, level

Behaviour:
- Reset rst_sys_ni, asynchronous, active-low; clock clk_sys_i. Under reset: device_rvalid_o=0, device_rdata_o=0, irq_o=0, FIFO empty, sticky flags 0, CTRL=0, FSM IDLE, both sync flops=1.
- uart_rx_i passes a 2-flop synchroniser; all logic uses the synced value rx_s.
- FSM IDLE: 1->0 edge on rx_s loads bit counter with ClksPerBit/2 -> START.
- START: at count expiry sample rx_s; 1 = glitch -> IDLE, nothing pushed; 0 -> DATA, counter = ClksPerBit, bit index 0.
- DATA: every ClksPerBit cycles sample rx_s into shift register, LSB first; after bit 7 -> STOP.
- STOP: after ClksPerBit sample rx_s. 1 = valid frame -> push byte; 0 = framing error -> set FERR, byte discarded. Either way -> IDLE; next start edge accepted the following cycle.
- Push when FIFO full and no same-cycle pop: byte dropped, OVF set, FIFO unchanged.
- Registers (offset = addr[3:2]*4):
  0x0 RXDATA (RO): rdata = {24'b0, head byte}; read pops the head. Read when empty returns 0, no pop, no error.
  0x4 STATUS: [0] empty, [1] full, [2] OVF sticky, [3] FERR sticky, [14:8] level (0..FifoDepth), rest 0. Write with be[0]: W1C on bits 2 and 3.
  0x8 CTRL (RW): [0] irq_en; other bits read 0. Write requires be[0].
  0xC: reads 0, writes ignored.
- Writes to RXDATA are ignored. Writes with be[0]=0 have no effect.
- Every request, read or write, produces device_rvalid_o=1 exactly one cycle later. device_rdata_o is registered and captured at request time, so the popped byte is the one returned. device_rdata_o=0 for write responses. Back-to-back requests on consecutive cycles are supported.
- Simultaneous push and pop:
  - Full: both succeed, level stays FifoDepth, OVF not set.
  - Empty: the read returns 0, the push succeeds, level becomes 1.
- Simultaneous hardware set and W1C of the same sticky bit: set wins.
- irq_o = CTRL.irq_en & ~empty, registered (one-cycle lag after a FIFO or CTRL change).
- FIFO is a circular buffer with read and write pointers of log2(FifoDepth)+1 bits; pointers wrap naturally.

Test Plan:
- Drive 0xA5 frame at 434 clks/bit -> after the stop-bit sample, STATUS reads 0x0000_0100. Read 0x0 -> rvalid 1 cycle later with rdata 0x0000_00A5. STATUS then reads 0x0000_0001.
- Pulse rx low for 100 cycles then high -> no push, STATUS stays 0x1. A valid 0x3C frame sent immediately afterwards is received correctly.
- Frame 0x55 with stop bit 0 -> STATUS = 0x0000_0009 (FERR set, FIFO empty). Write 0x8 to 0x4 -> STATUS = 0x1.
- Send 9 bytes 0x01..0x09 with no reads -> STATUS = 0x0000_0806 (level 8, full, OVF). Eight reads return 0x01..0x08 in order; a ninth read returns 0.
- CTRL=1 with FIFO empty -> irq_o=0. Byte arrives -> irq_o=1 one cycle after the push. Read RXDATA -> irq_o=0 one cycle after the pop. Write CTRL=0 with data present -> irq_o=0.
- Assert reset mid-DATA with 3 bytes queued -> all outputs 0, STATUS reads 0x1 after release. The next full frame is received intact.
